// File: rtl/text_console_writer_pkg.sv
// Shared constants and types for the text console writer: geometry defaults,
// control codes, FSM states and the cursor command set.
package text_console_pkg;
  localparam int DEF_DEPTH     = 1000;
  localparam int DEF_LINE_LEN  = 79;
  localparam int DEF_NUM_LINES = 12;
  localparam int DEF_TAB_W     = 8;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  typedef enum logic [2:0] {
    CUR_NONE, CUR_ADV, CUR_NL, CUR_CR, CUR_BACK, CUR_TAB, CUR_HOME
  } cur_cmd_e;

  function automatic logic is_printable(logic [7:0] c);
    return (c >= CH_SP) && (c <= CH_TILDE);
  endfunction
endpackage

// File: rtl/text_console_writer_if.sv
// CPU-side character port of the text console: char handshake, clear pulse,
// and status (busy, cursor position).
interface text_console_writer_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic [7:0] char_color;
  logic       char_ready;
  logic       clear_req;
  logic       busy;
  logic [3:0] cursor_row;
  logic [6:0] cursor_col;

  modport master (
    output char_valid, char_data, char_color, clear_req,
    input  char_ready, busy, cursor_row, cursor_col
  );
  modport slave (
    input  char_valid, char_data, char_color, clear_req,
    output char_ready, busy, cursor_row, cursor_col
  );
endinterface

// File: rtl/text_console_writer_cursor.sv
// Cursor row/column registers with wrap handling; idx is the row-major cell
// address of the current position, available in the same cycle.
module text_cursor
  import text_console_pkg::*;
#(
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int TAB_W     = DEF_TAB_W,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  cur_cmd_e      cmd,
  output logic [3:0]    row,
  output logic [6:0]    col,
  output logic [AW-1:0] idx
);
  logic [3:0] row_nl;
  int         tab_stop;

  always_comb begin
    row_nl   = (row == 4'(NUM_LINES - 1)) ? 4'd0 : row + 4'd1;
    tab_stop = (int'(col) / TAB_W + 1) * TAB_W;
    idx      = AW'(int'(row) * LINE_LEN + int'(col));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else begin
      unique case (cmd)
        CUR_HOME: begin row <= '0; col <= '0; end
        CUR_ADV: begin
          if (col == 7'(LINE_LEN - 1)) begin
            col <= '0;
            row <= row_nl;
          end else col <= col + 7'd1;
        end
        CUR_NL:   begin col <= '0; row <= row_nl; end
        CUR_CR:   col <= '0;
        CUR_BACK: if (col != '0) col <= col - 7'd1;
        CUR_TAB: begin
          // a tab stop past the last column behaves like a newline
          if (tab_stop >= LINE_LEN) begin
            col <= '0;
            row <= row_nl;
          end else col <= 7'(tab_stop);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/text_console_writer.sv
// Text console writer: accepts chars from the CPU port, interprets control
// codes, tracks the cursor and owns the text/color cell arrays.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int TAB_W     = DEF_TAB_W,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  text_console_writer_if.slave  bus,
  output logic [DEPTH-1:0][7:0] text_mem,
  output logic [DEPTH-1:0][7:0] text_color
);
  state_e        state, state_nx;
  logic [AW-1:0] clr_addr, clr_nx;
  logic [AW-1:0] cur_idx, wr_addr;
  logic [7:0]    wr_char, wr_color;
  logic          we, take;
  cur_cmd_e      cmd;

  text_cursor #(
    .LINE_LEN(LINE_LEN), .NUM_LINES(NUM_LINES), .TAB_W(TAB_W), .AW(AW)
  ) u_cursor (
    .clk(clk), .rst(rst), .cmd(cmd),
    .row(bus.cursor_row), .col(bus.cursor_col), .idx(cur_idx)
  );

  assign bus.char_ready = (state == ST_IDLE) && !bus.clear_req;
  assign bus.busy       = (state == ST_CLEAR);
  assign take           = bus.char_valid && bus.char_ready;

  always_comb begin
    state_nx = state;
    clr_nx   = clr_addr;
    cmd      = CUR_NONE;
    we       = 1'b0;
    wr_addr  = clr_addr;
    wr_char  = 8'h00;
    wr_color = 8'h00;
    unique case (state)
      ST_CLEAR: begin
        we = 1'b1;
        if (bus.clear_req) begin
          clr_nx = '0;
          cmd    = CUR_HOME;
        end else if (clr_addr == AW'(DEPTH - 1)) state_nx = ST_IDLE;
        else clr_nx = clr_addr + AW'(1);
      end
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_nx = ST_CLEAR;
          clr_nx   = '0;
          cmd      = CUR_HOME;
        end else if (take) begin
          unique case (bus.char_data)
            CH_LF:  cmd = CUR_NL;
            CH_CR:  cmd = CUR_CR;
            CH_TAB: cmd = CUR_TAB;
            CH_FF: begin
              state_nx = ST_CLEAR;
              clr_nx   = '0;
              cmd      = CUR_HOME;
            end
            CH_BS: begin
              // erase the cell we step back onto; no-op at column 0
              if (bus.cursor_col != '0) begin
                cmd      = CUR_BACK;
                we       = 1'b1;
                wr_addr  = cur_idx - AW'(1);
                wr_char  = CH_SP;
                wr_color = bus.char_color;
              end
            end
            default: begin
              if (is_printable(bus.char_data)) begin
                cmd      = CUR_ADV;
                we       = 1'b1;
                wr_addr  = cur_idx;
                wr_char  = bus.char_data;
                wr_color = bus.char_color;
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_nx;
    end
  end

  // cell arrays carry no reset; the clear sweep defines their contents
  always_ff @(posedge clk) begin
    if (we) begin
      text_mem[wr_addr]   <= wr_char;
      text_color[wr_addr] <= wr_color;
    end
  end
endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed scenarios plus random streams,
// checked each cycle against a cell/cursor model of the console.
module tb_text_console_writer;
  logic clk = 1'b0;
  logic rst;
  logic [999:0][7:0] text_mem, text_color;

  text_console_writer_if bus();

  text_console_writer dut (
    .clk(clk), .rst(rst), .bus(bus),
    .text_mem(text_mem), .text_color(text_color)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [7:0] m_mem [1000];
  logic [7:0] m_col [1000];
  int m_r, m_c, m_sweep;
  bit m_on = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic m_start_clear();
    m_sweep = 1000;
    m_r = 0;
    m_c = 0;
    for (int i = 0; i < 1000; i++) begin
      m_mem[i] = 8'h00;
      m_col[i] = 8'h00;
    end
  endtask

  task automatic m_newline();
    m_c = 0;
    m_r = (m_r + 1) % 12;
  endtask

  task automatic m_char(input logic [7:0] c, input logic [7:0] k);
    int t;
    case (c)
      8'h0A: m_newline();
      8'h0D: m_c = 0;
      8'h0C: m_start_clear();
      8'h08: if (m_c > 0) begin
        m_c--;
        m_mem[m_r * 79 + m_c] = 8'h20;
        m_col[m_r * 79 + m_c] = k;
      end
      8'h09: begin
        t = (m_c / 8 + 1) * 8;
        if (t >= 79) m_newline(); else m_c = t;
      end
      default: if (c >= 8'h20 && c <= 8'h7E) begin
        m_mem[m_r * 79 + m_c] = c;
        m_col[m_r * 79 + m_c] = k;
        m_c++;
        if (m_c == 79) m_newline();
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1;
      m_start_clear();
    end else if (m_on) begin
      if (m_sweep > 0) begin
        if (bus.clear_req) m_sweep = 1000; else m_sweep--;
      end else if (bus.clear_req) m_start_clear();
      else if (bus.char_valid) m_char(bus.char_data, bus.char_color);
    end
  end

  always @(negedge clk) begin
    int bad;
    if (m_on) begin
      chk("busy", int'(bus.busy), int'(m_sweep > 0));
      chk("char_ready", int'(bus.char_ready), int'(m_sweep == 0 && !bus.clear_req));
      chk("cursor_row", int'(bus.cursor_row), m_r);
      chk("cursor_col", int'(bus.cursor_col), m_c);
      if (m_sweep == 0) begin
        bad = -1;
        for (int i = 0; i < 1000; i++)
          if (bad < 0 && (text_mem[i] !== m_mem[i] || text_color[i] !== m_col[i])) bad = i;
        n_chk++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL cells at idx %0d: got char %0h color %0h expected char %0h color %0h",
                   bad, text_mem[bad], text_color[bad], m_mem[bad], m_col[bad]);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] k);
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    bus.char_color = k;
    sync();
    bus.char_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.busy) n++; else break;
    end
    sync();
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (bus.busy && cyc < 3000) begin
      sync();
      cyc++;
    end
    if (bus.busy) chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    int n, r;
    logic [7:0] c;
    rst = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.char_color = 8'h00;
    bus.clear_req  = 1'b0;
    sync();
    rst = 1'b0;
    count_busy(n);
    chk("reset_sweep_len", n, 1000);
    chk("reset_cell0", int'(text_mem[0]), 0);
    chk("reset_cell999", int'(text_mem[999]), 0);
    chk("reset_color500", int'(text_color[500]), 0);

    send(8'h48, 8'd2);
    send(8'h49, 8'd2);
    chk("hi_mem0", int'(text_mem[0]), 8'h48);
    chk("hi_mem1", int'(text_mem[1]), 8'h49);
    chk("hi_color1", int'(text_color[1]), 2);
    chk("hi_col", int'(bus.cursor_col), 2);

    send(8'h0D, 8'd0);
    for (int i = 0; i < 79; i++) send(8'h41, 8'd3);
    send(8'h42, 8'd1);
    chk("wrap_mem79", int'(text_mem[79]), 8'h42);
    chk("wrap_mem78", int'(text_mem[78]), 8'h41);
    chk("wrap_row", int'(bus.cursor_row), 1);
    chk("wrap_col", int'(bus.cursor_col), 1);

    for (int i = 0; i < 10; i++) send(8'h0A, 8'd0);
    chk("lf_row11", int'(bus.cursor_row), 11);
    send(8'h0A, 8'd0);
    chk("lf_rowwrap", int'(bus.cursor_row), 0);
    chk("lf_col", int'(bus.cursor_col), 0);

    send(8'h41, 8'd1);
    send(8'h42, 8'd1);
    send(8'h43, 8'd1);
    send(8'h08, 8'd1);
    chk("bs_mem2", int'(text_mem[2]), 8'h20);
    chk("bs_col", int'(bus.cursor_col), 2);
    send(8'h43, 8'd1);
    send(8'h09, 8'd0);
    chk("tab_col8", int'(bus.cursor_col), 8);
    for (int i = 0; i < 8; i++) send(8'h09, 8'd0);
    chk("tab_col72", int'(bus.cursor_col), 72);
    send(8'h09, 8'd0);
    chk("tab_nl_row", int'(bus.cursor_row), 1);
    chk("tab_nl_col", int'(bus.cursor_col), 0);

    bus.clear_req  = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h5A;
    bus.char_color = 8'd1;
    sync();
    bus.clear_req  = 1'b0;
    bus.char_valid = 1'b0;
    count_busy(n);
    chk("clear_sweep_len", n, 1000);
    chk("clear_mem79", int'(text_mem[79]), 0);
    chk("clear_mem0", int'(text_mem[0]), 0);
    chk("clear_col", int'(bus.cursor_col), 0);

    bus.clear_req = 1'b1;
    sync();
    bus.clear_req = 1'b0;
    repeat (500) sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    count_busy(n);
    chk("rst_mid_sweep_len", n, 1000);

    for (int cyc = 0; cyc < 7000; cyc++) begin
      r = $urandom_range(0, 99);
      if (r < 60) c = 8'($urandom_range(32, 126));
      else if (r < 68) c = 8'h0A;
      else if (r < 74) c = 8'h0D;
      else if (r < 82) c = 8'h08;
      else if (r < 90) c = 8'h09;
      else if (r == 90) c = ($urandom_range(0, 9) == 0) ? 8'h0C : 8'h41;
      else c = 8'($urandom_range(0, 255));
      bus.char_valid = ($urandom_range(0, 9) < 7);
      bus.char_data  = c;
      bus.char_color = 8'($urandom_range(0, 3));
      bus.clear_req  = ($urandom_range(0, 799) == 0);
      rst            = ($urandom_range(0, 2999) == 0);
      sync();
    end
    bus.char_valid = 1'b0;
    bus.clear_req  = 1'b0;
    rst = 1'b0;
    sync();
    wait_idle();
    repeat (3) sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
